y_path_arbiter: RTL and testbench

Sequencer/arbiter for the shared y operand register: grants the y register's routing to one of three requesting units (multiplier, divisor, square-root) at a time. It drives the register's `from_mul` / `from_div` / `from_sqr` mode-select lines and holds the selected mode steady for the whole operation, as that register requires. It returns the path to the ALU (all selects low) between operations. Arbitration among the units is round-robin, with a per-operation timeout.

---
 rtl/y_path_arbiter_if.sv | 30 +++
 rtl/y_path_arbiter.sv | 137 +++++++++++++
 tb/tb_y_path_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y_path_arbiter_if.sv
// Handshake bundle between the y-path arbiter and the mul/div/sqr units.
// The units drive requests and done pulses; the arbiter drives the mode selects and status.
interface y_path_arbiter_if;
   logic       req_mul;
   logic       req_div;
   logic       req_sqr;
   logic       done_mul;
   logic       done_div;
   logic       done_sqr;
   logic       sel_mul;
   logic       sel_div;
   logic       sel_sqr;
   logic [1:0] owner;
   logic       busy;
   logic       timeout_err;

   modport master (
      output req_mul, req_div, req_sqr,
      output done_mul, done_div, done_sqr,
      input  sel_mul, sel_div, sel_sqr,
      input  owner, busy, timeout_err
   );

   modport slave (
      input  req_mul, req_div, req_sqr,
      input  done_mul, done_div, done_sqr,
      output sel_mul, sel_div, sel_sqr,
      output owner, busy, timeout_err
   );
endinterface

// File: rtl/y_path_arbiter.sv
// Round-robin arbiter granting the shared y operand register to mul, div or sqr,
// holding the mode select for the whole operation, with a per-grant timeout.
module y_path_arbiter #(
   parameter int TIMEOUT = 16
) (
   input logic             clk,
   input logic             rst,
   y_path_arbiter_if.slave yif
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, RELEASE} state_t;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [1:0] owner_q, owner_d;
   logic       busy_q, busy_d;
   logic       timeout_err_q, timeout_err_d;
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0] cnt_q, cnt_d;

   logic [2:0] req;
   logic [2:0] done;
   logic [2:0] req_rot;
   logic [1:0] offset;
   logic [2:0] win_sum;
   logic [1:0] winner;
   logic       owner_done;
   logic       go_release;

   assign req  = {yif.req_sqr, yif.req_div, yif.req_mul};
   assign done = {yif.done_sqr, yif.done_div, yif.done_mul};

   // Rotate requests so bit 0 is the unit rr_ptr currently favours.
   always_comb begin
      case (rr_ptr_q)
         2'd1:    req_rot = {req[0], req[2], req[1]};
         2'd2:    req_rot = {req[1], req[0], req[2]};
         default: req_rot = req;
      endcase
      if (req_rot[0])      offset = 2'd0;
      else if (req_rot[1]) offset = 2'd1;
      else                 offset = 2'd2;
      win_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
      winner  = (win_sum >= 3'd3) ? 2'(win_sum - 3'd3) : win_sum[1:0];
   end

   // Only the current owner's done pulse can end a grant.
   always_comb begin
      case (owner_q)
         2'd1:    owner_done = done[0];
         2'd2:    owner_done = done[1];
         2'd3:    owner_done = done[2];
         default: owner_done = 1'b0;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      owner_d       = owner_q;
      busy_d        = busy_q;
      timeout_err_d = 1'b0;
      rr_ptr_d      = rr_ptr_q;
      cnt_d         = cnt_q;
      go_release    = 1'b0;

      case (state_q)
         IDLE: begin
            sel_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            if (|req) begin
               state_d  = LOAD;
               sel_d    = 3'b001 << winner;
               owner_d  = winner + 2'd1;
               busy_d   = 1'b1;
               rr_ptr_d = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
            end
         end
         LOAD: begin
            cnt_d = '0;
            if (owner_done) go_release = 1'b1;
            else            state_d    = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 8'd1;
            if (owner_done) begin
               go_release = 1'b1;
            end else if (cnt_q == LAST_CNT) begin
               go_release    = 1'b1;
               timeout_err_d = 1'b1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      if (go_release) begin
         state_d = RELEASE;
         sel_d   = '0;
         owner_d = '0;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         sel_q         <= '0;
         owner_q       <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         rr_ptr_q      <= 2'd0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         owner_q       <= owner_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
         rr_ptr_q      <= rr_ptr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign yif.sel_mul     = sel_q[0];
   assign yif.sel_div     = sel_q[1];
   assign yif.sel_sqr     = sel_q[2];
   assign yif.owner       = owner_q;
   assign yif.busy        = busy_q;
   assign yif.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_y_path_arbiter.sv
// Scoreboard bench for y_path_arbiter: stimulus queues expected grants, a monitor
// measures each completed grant (owner, select length, timeout flag, preceding gap).
module tb_y_path_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   y_path_arbiter_if yif ();

   y_path_arbiter #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .yif (yif)
   );

   always #5 clk = ~clk;

   typedef struct {
      int owner;
      int len;
      int terr;
      int gap;   // -1: not checked
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic push(input int o, input int l, input int t, input int g);
      exp_t e;
      e.owner = o; e.len = l; e.terr = t; e.gap = g;
      exp_q.push_back(e);
      $display("queued grant: owner=%0d len=%0d timeout=%0d gap=%0d", o, l, t, g);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // u = 0 mul, 1 div, 2 sqr, 3 any
   task automatic wait_sel(input int u);
      int n;
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 20) begin
         tick();
         n++;
         case (u)
            0:       hit = yif.sel_mul;
            1:       hit = yif.sel_div;
            2:       hit = yif.sel_sqr;
            default: hit = yif.sel_mul | yif.sel_div | yif.sel_sqr;
         endcase
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL wait_sel%0d: no grant within 20 cycles", u);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_sel"}, int'({yif.sel_sqr, yif.sel_div, yif.sel_mul}), 0);
      chk({tag, "_owner"}, int'(yif.owner), 0);
      chk({tag, "_busy"}, int'(yif.busy), 0);
      chk({tag, "_timeout_err"}, int'(yif.timeout_err), 0);
   endtask

   function automatic int sel2own(input logic [2:0] s);
      case (s)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 3;
         default: return 0;
      endcase
   endfunction

   // Monitor: one record per grant, compared at its RELEASE cycle.
   logic [2:0] m_sel;
   logic [2:0] m_prev = '0;
   int         m_len = 0;
   int         m_gap = 0;
   int         m_cur_gap = 0;
   int         m_owner = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_prev = '0;
            m_gap  = 0;
            m_len  = 0;
         end else begin
            m_sel = {yif.sel_sqr, yif.sel_div, yif.sel_mul};
            chk("sel_onehot", int'($countones(m_sel) <= 1), 1);
            chk("owner_vs_sel", int'(yif.owner), sel2own(m_sel));
            chk("busy_vs_sel", int'(yif.busy), int'(m_sel != 3'b000));
            if (m_sel != 3'b000) begin
               if (m_prev == 3'b000) begin
                  m_len     = 1;
                  m_cur_gap = m_gap;
                  m_owner   = int'(yif.owner);
               end else begin
                  m_len++;
                  chk("sel_held", int'(m_sel), int'(m_prev));
               end
            end else if (m_prev != 3'b000) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_grant: owner %0d len %0d, expected none", m_owner, m_len);
               end else begin
                  e = exp_q.pop_front();
                  chk("grant_owner", m_owner, e.owner);
                  chk("grant_len", m_len, e.len);
                  chk("grant_timeout_err", int'(yif.timeout_err), e.terr);
                  if (e.gap >= 0) chk("grant_gap", m_cur_gap, e.gap);
                  $display("grant done: owner=%0d len=%0d timeout=%0d gap=%0d", m_owner, m_len,
                           yif.timeout_err, m_cur_gap);
               end
               m_gap = 1;
            end else begin
               m_gap++;
               chk("timeout_err_stray", int'(yif.timeout_err), 0);
            end
            m_prev = m_sel;
         end
      end
   end

   task automatic all_reqs(input logic v);
      yif.req_mul = v;
      yif.req_div = v;
      yif.req_sqr = v;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      all_reqs(1'b0);
      yif.done_mul = 1'b0;
      yif.done_div = 1'b0;
      yif.done_sqr = 1'b0;

      // Reset values, before any clock edge
      #2;
      chk_outputs_zero("reset");
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_outputs_zero("post_reset");

      // Single request with back-to-back regrant
      push(2, 4, 0, -1);
      push(2, 2, 0, 2);
      yif.req_div = 1'b1;
      wait_sel(1);
      tick(); tick(); tick();
      yif.done_div = 1'b1;
      tick();
      yif.done_div = 1'b0;
      wait_sel(1);
      tick();
      yif.done_div = 1'b1;
      yif.req_div  = 1'b0;
      tick();
      yif.done_div = 1'b0;
      tick(); tick(); tick();

      // Round-robin fairness from reset: mul, div, sqr, mul
      apply_reset();
      push(1, 3, 0, -1);
      push(2, 3, 0, 2);
      push(3, 3, 0, 2);
      push(1, 3, 0, 2);
      all_reqs(1'b1);
      for (int g = 0; g < 4; g++) begin
         wait_sel(3);
         tick(); tick();
         case (g)
            0, 3:    yif.done_mul = 1'b1;
            1:       yif.done_div = 1'b1;
            default: yif.done_sqr = 1'b1;
         endcase
         if (g == 3) all_reqs(1'b0);
         tick();
         yif.done_mul = 1'b0;
         yif.done_div = 1'b0;
         yif.done_sqr = 1'b0;
      end
      tick(); tick(); tick();

      // Timeout: select high 1 + TIMEOUT cycles, error flag in RELEASE
      push(3, 5, 1, -1);
      yif.req_sqr = 1'b1;
      wait_sel(2);
      yif.req_sqr = 1'b0;
      repeat (8) tick();

      // Spurious inputs: foreign done pulses and dropped request are ignored
      push(1, 3, 0, -1);
      yif.req_mul = 1'b1;
      wait_sel(0);
      yif.req_mul  = 1'b0;
      yif.done_div = 1'b1;
      tick();
      yif.done_div = 1'b0;
      yif.done_sqr = 1'b1;
      tick();
      yif.done_sqr = 1'b0;
      yif.done_mul = 1'b1;
      tick();
      yif.done_mul = 1'b0;
      tick(); tick(); tick();

      // Done pulses while idle must not create a grant
      yif.done_mul = 1'b1;
      yif.done_div = 1'b1;
      yif.done_sqr = 1'b1;
      tick();
      yif.done_mul = 1'b0;
      yif.done_div = 1'b0;
      yif.done_sqr = 1'b0;
      tick(); tick();

      // Done in the LOAD cycle: select high exactly one cycle
      push(1, 1, 0, -1);
      yif.req_mul = 1'b1;
      wait_sel(0);
      yif.done_mul = 1'b1;
      yif.req_mul  = 1'b0;
      tick();
      yif.done_mul = 1'b0;
      tick(); tick(); tick();

      // Asynchronous reset during RUN of div, then rr_ptr back at mul
      yif.req_div = 1'b1;
      wait_sel(1);
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk_outputs_zero("async_reset");
      @(posedge clk);
      #1;
      all_reqs(1'b1);
      tick();
      rst = 1'b1;
      push(1, 2, 0, -1);
      wait_sel(3);
      tick();
      yif.done_mul = 1'b1;
      all_reqs(1'b0);
      tick();
      yif.done_mul = 1'b0;
      repeat (5) tick();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
